fpga_wb_initiator: RTL and testbench
====================================

FPGA_WB_INITIATOR -- requirements
Module: fpga_wb_initiator

Interface
REQ-001 Parameters SHALL be: ADDRWIDTH, 9, Wishbone word-address width; DATAWIDTH, 32, data width; TIMEOUT_CYCLES, 255, maximum wait for ACK in cycles (1..255).
REQ-002 One clock; reset is asynchronous and active-high: WBs_CLK_i input 1, the bus clock; WBs_RST_i input 1, the reset.
REQ-003 cmd_valid_i input 1, command request; cmd_ready_o output 1, command accepted when high with cmd_valid_i.
REQ-004 cmd_we_i input 1, 1 = write, 0 = read; cmd_fix_i input 1, 1 = hold the address for all beats (FIFO port access).
REQ-005 cmd_adr_i input ADDRWIDTH, start word address; cmd_len_i input 4, beat count minus 1 (1..16 beats); cmd_be_i input 4, byte strobes for every beat.
REQ-006 wdat_valid_i input 1, wdat_i input DATAWIDTH, wdat_ready_o output 1: the write-data stream, one word per beat.
REQ-007 rsp_valid_o output 1, rsp_dat_o output DATAWIDTH, rsp_last_o output 1: read data, one single-cycle pulse per beat, no backpressure.
REQ-008 done_o output 1, single-cycle end-of-command pulse; err_o output 1, timeout flag, valid with done_o.
REQ-009 WBm_ADR_o output ADDRWIDTH, WBm_CYC_o output 1, WBm_STB_o output 1, WBm_WE_o output 1, WBm_RD_o output 1, WBm_BYTE_STB_o output 4, WBm_DAT_o output DATAWIDTH: the initiator-side bus outputs, all registered.
REQ-010 WBm_DAT_i input DATAWIDTH and WBm_ACK_i input 1: the responder read data and acknowledge.

Function
REQ-011 The FSM SHALL have the states IDLE, WDAT, REQ and GAP.
REQ-012 IDLE: cmd_ready_o=1; on accept, latch adr/len/we/fix/be, load beat counter=cmd_len_i, and go to WDAT if write, else REQ.
REQ-013 WDAT: wdat_ready_o=1; on wdat_valid_i, register wdat_i into WBm_DAT_o and go to REQ; otherwise stay with CYC/STB low.
REQ-014 REQ: CYC=STB=1, WE=we, RD=~we, BYTE_STB=be; hold all bus outputs stable until WBm_ACK_i is sampled high.
REQ-015 On the ACK edge: drop STB and CYC next cycle and go to GAP; for a read, register WBm_DAT_i to rsp_dat_o and pulse rsp_valid_o next cycle.
REQ-016 rsp_last_o SHALL be 1 with the pulse of the final beat.
REQ-017 GAP: lasts exactly one cycle with CYC=STB=0, which guarantees the responder sees a fresh strobe per beat.
REQ-018 GAP exit: if the beat counter is 0, pulse done_o (err_o=0) and go to IDLE.
REQ-019 GAP exit otherwise: decrement the counter, increment WBm_ADR_o by 1 modulo 2^ADDRWIDTH unless fix, and go to WDAT (write) or REQ (read).
REQ-020 Minimum read beat time SHALL be 3 cycles (REQ with ACK after 1 cycle, plus GAP); a 16-beat read with zero-wait ACK completes in 48 cycles plus 1 accept cycle.
REQ-021 Address wrap: start 0x1FF, len 1, incrementing, SHALL issue 0x1FF then 0x000.
REQ-022 An ACK seen outside REQ SHALL be ignored; cmd_valid_i outside IDLE SHALL be ignored (cmd_ready_o=0).

Reset
REQ-023 WBs_RST_i high at any time, including mid-burst, SHALL force IDLE immediately.
REQ-024 During reset all outputs SHALL be 0 (addresses and data included), except cmd_ready_o, which goes to 1 on the first clock after reset release.
REQ-025 An aborted command SHALL produce no done_o pulse.

Configuration
REQ-026 Macro FPGA_WB_INITIATOR_TIMEOUT_EN defined: an 8-bit counter clears on entry to REQ and counts each REQ cycle without ACK.
REQ-027 With the macro, reaching TIMEOUT_CYCLES SHALL drop CYC/STB next cycle, abandon the remaining beats, pulse done_o with err_o=1 and return to IDLE with no rsp_valid_o for that beat.
REQ-028 Macro undefined: REQ waits indefinitely for ACK, err_o is tied 0, and the counter is not built.

Verification
REQ-029 Single read: adr 0x002, len 0, responder ACKs after 1 cycle with 0x000000A5 -> one REQ cycle pair, rsp_valid_o pulse with rsp_dat_o=0x000000A5 and rsp_last_o=1, done_o 3 cycles after accept.
REQ-030 Fixed-address write burst: adr 0x040, len 3, fix=1, data 1,2,3,4 -> four strobes all at 0x040 with WBm_DAT_o 1..4, a one-cycle CYC-low gap between each, then done_o with err_o=0.
REQ-031 Write stall: wdat_valid_i withheld 5 cycles before beat 2 -> CYC/STB stay low those 5 cycles, then the burst resumes at adr+1.
REQ-032 Incrementing read wrap: adr 0x1FF, len 1 -> addresses 0x1FF then 0x000, two rsp pulses, last flag on the second only.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=8): no ACK -> STB drops after 8 REQ cycles, done_o=1 with err_o=1, no rsp; macro off -> STB stays high for 100+ cycles.
REQ-034 Reset mid-burst: WBs_RST_i asserted during beat 2 of a 4-beat read -> all outputs 0 asynchronously, no done_o, and a new command is accepted after release.

Source files
------------

// File: rtl/fpga_wb_initiator.sv
// Burst Wishbone initiator: each beat is its own CYC/STB cycle, followed by a one-cycle idle gap.
// Optional ACK timeout is built when FPGA_WB_INITIATOR_TIMEOUT_EN is defined.
module fpga_wb_initiator #(
  parameter int ADDRWIDTH      = 9,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic                 cmd_fix_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [3:0]           cmd_len_i,
  input  logic [3:0]           cmd_be_i,
  input  logic                 wdat_valid_i,
  input  logic [DATAWIDTH-1:0] wdat_i,
  output logic                 wdat_ready_o,
  output logic                 rsp_valid_o,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_last_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic                 WBm_RD_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, WDAT, REQ, GAP} state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   adr_q, adr_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   fix_q, fix_d;
  logic [3:0]             be_q, be_d;
  logic [DATAWIDTH-1:0]   dat_q, dat_d;
  logic                   cyc_q, cyc_d;
  logic                   stb_q, stb_d;
  logic                   bwe_q, bwe_d;
  logic                   brd_q, brd_d;
  logic [3:0]             bbe_q, bbe_d;
  logic                   rsp_v_q, rsp_v_d;
  logic [DATAWIDTH-1:0]   rsp_d_q, rsp_d_d;
  logic                   rsp_l_q, rsp_l_d;
  logic                   done_q, done_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   wdat_rdy_q, wdat_rdy_d;
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]             tmo_q, tmo_d;
  logic                   err_q, err_d;
`endif

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q    <= IDLE;
      adr_q      <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      fix_q      <= 1'b0;
      be_q       <= '0;
      dat_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      bwe_q      <= 1'b0;
      brd_q      <= 1'b0;
      bbe_q      <= '0;
      rsp_v_q    <= 1'b0;
      rsp_d_q    <= '0;
      rsp_l_q    <= 1'b0;
      done_q     <= 1'b0;
      cmd_rdy_q  <= 1'b0;
      wdat_rdy_q <= 1'b0;
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      fix_q      <= fix_d;
      be_q       <= be_d;
      dat_q      <= dat_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      bwe_q      <= bwe_d;
      brd_q      <= brd_d;
      bbe_q      <= bbe_d;
      rsp_v_q    <= rsp_v_d;
      rsp_d_q    <= rsp_d_d;
      rsp_l_q    <= rsp_l_d;
      done_q     <= done_d;
      cmd_rdy_q  <= cmd_rdy_d;
      wdat_rdy_q <= wdat_rdy_d;
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    fix_d   = fix_q;
    be_d    = be_q;
    dat_d   = dat_q;
    rsp_v_d = 1'b0;
    rsp_d_d = rsp_d_q;
    rsp_l_d = 1'b0;
    done_d  = 1'b0;
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_rdy_q) begin
          adr_d   = cmd_adr_i;
          cnt_d   = cmd_len_i;
          we_d    = cmd_we_i;
          fix_d   = cmd_fix_i;
          be_d    = cmd_be_i;
          state_d = cmd_we_i ? WDAT : REQ;
        end
      end
      WDAT: begin
        if (wdat_valid_i && wdat_rdy_q) begin
          dat_d   = wdat_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (WBm_ACK_i) begin
          state_d = GAP;
          if (!we_q) begin
            rsp_v_d = 1'b1;
            rsp_d_d = WBm_DAT_i;
            rsp_l_d = (cnt_q == 4'd0);
          end
        end
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          // Abandon the whole command, not just this beat.
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          if (!fix_q) adr_d = adr_q + ADDRWIDTH'(1);
          state_d = we_q ? WDAT : REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus controls follow the next state so they are registered and stable through REQ.
    cyc_d      = (state_d == REQ);
    stb_d      = (state_d == REQ);
    bwe_d      = (state_d == REQ) &&  we_d;
    brd_d      = (state_d == REQ) && !we_d;
    bbe_d      = (state_d == REQ) ? be_d : 4'd0;
    cmd_rdy_d  = (state_d == IDLE);
    wdat_rdy_d = (state_d == WDAT);
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
    if (state_d == REQ && state_q != REQ) tmo_d = '0;
`endif
  end

  assign cmd_ready_o    = cmd_rdy_q;
  assign wdat_ready_o   = wdat_rdy_q;
  assign rsp_valid_o    = rsp_v_q;
  assign rsp_dat_o      = rsp_d_q;
  assign rsp_last_o     = rsp_l_q;
  assign done_o         = done_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = stb_q;
  assign WBm_WE_o       = bwe_q;
  assign WBm_RD_o       = brd_q;
  assign WBm_BYTE_STB_o = bbe_q;
  assign WBm_DAT_o      = dat_q;
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_wb_initiator.sv
// Bench for fpga_wb_initiator: command table plus stall, no-ACK and mid-burst reset sequences.
module tb_fpga_wb_initiator;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_we, cmd_fix;
  logic [AW-1:0] cmd_adr;
  logic [3:0]    cmd_len, cmd_be;
  logic          wdat_valid, wdat_ready;
  logic [DW-1:0] wdat;
  logic          rsp_valid, rsp_last, done, err;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] wb_adr;
  logic          wb_cyc, wb_stb, wb_we, wb_rd, wb_ack;
  logic [3:0]    wb_bstb;
  logic [DW-1:0] wb_dat_o, wb_dat_i;

  fpga_wb_initiator #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we), .cmd_fix_i(cmd_fix),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_be_i(cmd_be),
    .wdat_valid_i(wdat_valid), .wdat_i(wdat), .wdat_ready_o(wdat_ready),
    .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_last_o(rsp_last),
    .done_o(done), .err_o(err),
    .WBm_ADR_o(wb_adr), .WBm_CYC_o(wb_cyc), .WBm_STB_o(wb_stb), .WBm_WE_o(wb_we),
    .WBm_RD_o(wb_rd), .WBm_BYTE_STB_o(wb_bstb), .WBm_DAT_o(wb_dat_o),
    .WBm_DAT_i(wb_dat_i), .WBm_ACK_i(wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] adr; logic we; logic [DW-1:0] dat; logic [3:0] be; } beat_t;
  typedef struct { logic [DW-1:0] dat; logic last; } rsp_t;
  typedef struct {
    logic we; logic fix; logic [AW-1:0] adr; logic [3:0] len; logic [3:0] be;
    int lat; logic [DW-1:0] wbase; int exp_cyc;
  } vec_t;

  int tests = 0, fails = 0;
  beat_t exp_bus[$];
  rsp_t  exp_rsp[$];
  logic [DW-1:0] wq[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int ack_lat = 0, ack_en = 1;
  int stall_beat = -1, stall_len = 0, stall_cnt = 0, wbeat = 0;
  int done_cnt = 0, rsp_seen = 0, run = 0;
  int runs[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {41'd0, wb_adr, wb_cyc, wb_stb, wb_we, wb_rd, wb_bstb, wb_dat_o,
            rsp_valid, rsp_dat, rsp_last, done, err, cmd_ready, wdat_ready};
  endfunction

  // Responder: ACK pulse ack_lat cycles after it first sees a strobe; checks each beat.
  initial begin
    logic stb_s;
    int wcnt;
    beat_t b;
    wb_ack = 1'b0; wb_dat_i = '0; wcnt = 0;
    forever begin
      @(posedge clk);
      stb_s = wb_cyc && wb_stb;
      #1;
      if (rst) begin
        wb_ack = 1'b0; wcnt = 0;
      end else if (wb_ack) begin
        wb_ack = 1'b0;
      end else if (stb_s && ack_en != 0) begin
        if (wcnt == ack_lat) begin
          wcnt = 0;
          wb_ack = 1'b1;
          if (wb_we) mem[wb_adr] = wb_dat_o;
          else       wb_dat_i = mem[wb_adr];
          if (exp_bus.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            b = exp_bus.pop_front();
            check("beat_adr", wb_adr, b.adr);
            check("beat_we_rd", {wb_we, wb_rd}, {b.we, ~b.we});
            check("beat_be", wb_bstb, b.be);
            if (b.we) check("beat_wdat", wb_dat_o, b.dat);
          end
        end else wcnt++;
      end else if (!stb_s) wcnt = 0;
    end
  end

  // Write-data source with an optional stall counted in cycles the DUT is asking for data.
  initial begin
    logic hs, rdy;
    logic [DW-1:0] tmp;
    wdat_valid = 1'b0; wdat = '0;
    forever begin
      @(posedge clk);
      rdy = wdat_ready;
      hs  = wdat_ready && wdat_valid;
      #1;
      if (rst) stall_cnt = 0;
      else if (hs) begin
        tmp = wq.pop_front();
        wbeat++;
        if (wbeat == stall_beat) stall_cnt = stall_len;
      end else if (rdy && stall_cnt > 0) stall_cnt--;
      wdat_valid = (wq.size() > 0) && (stall_cnt == 0);
      if (wq.size() > 0) wdat = wq[0];
      else wdat = '0;
    end
  end

  // Response/done monitor and CYC-low run tracker.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid) begin
          rsp_seen++;
          if (exp_rsp.size() == 0) check("unexpected_rsp", 1, 0);
          else begin
            r = exp_rsp.pop_front();
            check("rsp_dat", rsp_dat, r.dat);
            check("rsp_last", rsp_last, r.last);
          end
        end
        if (done) done_cnt++;
        if (!wb_cyc) run++;
        else if (run > 0) begin runs.push_back(run); run = 0; end
      end
    end
  end

  task automatic push_expect(input vec_t v);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i <= int'(v.len); i++) begin
      a = v.fix ? v.adr : v.adr + AW'(i);
      if (v.we) begin
        d = v.wbase + DW'(i);
        wq.push_back(d);
        exp_bus.push_back('{a, 1'b1, d, v.be});
      end else begin
        exp_bus.push_back('{a, 1'b0, '0, v.be});
        exp_rsp.push_back('{mem[a], (i == int'(v.len))});
      end
    end
  endtask

  task automatic send_cmd(input vec_t v);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_we = v.we; cmd_fix = v.fix; cmd_adr = v.adr; cmd_len = v.len; cmd_be = v.be;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic run_cmd(input vec_t v, output int n);
    ack_lat = v.lat; ack_en = 1; wbeat = 0;
    push_expect(v);
    send_cmd(v);
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 600) check("done_wait_expired", 0, 1);
    check("done_err", err, 0);
    @(negedge clk);
    check("done_single_pulse", done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_bus.delete(); exp_rsp.delete(); wq.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, r0, nstb;
    vec_t v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_fix = 1'b0;
    cmd_adr = '0; cmd_len = '0; cmd_be = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h5A00_0000 | DW'(i);
    mem[2] = 32'h0000_00A5;

    //          we    fix   adr     len   be    lat wbase         cyc
    vecs[0] = '{1'b0, 1'b0, 9'h002, 4'd0,  4'hF, 0, 32'h0,        3};
    vecs[1] = '{1'b1, 1'b1, 9'h040, 4'd3,  4'hF, 0, 32'h1,        16};
    vecs[2] = '{1'b0, 1'b0, 9'h1FF, 4'd1,  4'hF, 0, 32'h0,        6};
    vecs[3] = '{1'b0, 1'b0, 9'h010, 4'd15, 4'hF, 0, 32'h0,        48};
    vecs[4] = '{1'b1, 1'b0, 9'h100, 4'd2,  4'h5, 2, 32'h100,      18};
    vecs[5] = '{1'b0, 1'b0, 9'h040, 4'd0,  4'h3, 1, 32'h0,        4};

    repeat (3) @(negedge clk);
    check("reset_outputs_zero", all_outs(), 0);
    rst = 1'b0;
    #1 check("ready_low_before_clock", cmd_ready, 0);
    @(posedge clk); #1;
    check("ready_after_release", cmd_ready, 1);

    for (int k = 0; k < 6; k++) begin
      run_cmd(vecs[k], n);
      check($sformatf("vec%0d_cycles", k), n, vecs[k].exp_cyc);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_bus_drained", k), exp_bus.size(), 0);
      check($sformatf("vec%0d_rsp_drained", k), exp_rsp.size(), 0);
      check($sformatf("vec%0d_wdat_drained", k), wq.size(), 0);
    end

    // Write stall of 5 cycles before the second beat.
    v = '{1'b1, 1'b0, 9'h080, 4'd3, 4'hF, 0, 32'h10, 21};
    stall_beat = 1; stall_len = 5;
    runs.delete();
    run_cmd(v, n);
    stall_beat = -1;
    check("stall_cycles", n, 21);
    check("stall_run_count", runs.size(), 4);
    if (runs.size() == 4) begin
      check("stall_gap_beat1", runs[1], 7);
      check("stall_gap_beat2", runs[2], 2);
      check("stall_gap_beat3", runs[3], 2);
    end
    check("stall_bus_drained", exp_bus.size(), 0);

    // Responder never ACKs; commands offered meanwhile must be ignored.
    ack_en = 0;
    d0 = done_cnt; r0 = rsp_seen;
    v = '{1'b0, 1'b0, 9'h020, 4'd0, 4'hF, 0, 32'h0, 0};
    send_cmd(v);
    cmd_valid = 1'b1; cmd_adr = 9'h0AA; cmd_we = 1'b1;
    nstb = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_ignores_cmd_ready", cmd_ready, 0);
      check("busy_ignores_cmd_adr", wb_adr, 9'h020);
      if (wb_stb) nstb++;
    end
    cmd_valid = 1'b0;
    while (wb_stb && nstb < 120) begin
      @(negedge clk);
      if (wb_stb) nstb++;
    end
`ifdef FPGA_WB_INITIATOR_TIMEOUT_EN
    check("timeout_stb_cycles", nstb, 8);
    check("timeout_done", done, 1);
    check("timeout_err", err, 1);
    @(negedge clk);
    check("timeout_no_rsp", rsp_seen, r0);
    check("timeout_done_count", done_cnt, d0 + 1);
    check("timeout_back_idle", cmd_ready, 1);
`else
    check("noack_stb_held", nstb, 120);
    check("noack_stb_still_high", wb_stb, 1);
    check("noack_no_done", done_cnt, d0);
    do_reset();
    @(posedge clk); #1;
    check("noack_recovered_ready", cmd_ready, 1);
    check("noack_no_rsp", rsp_seen, r0);
`endif
    ack_en = 1;

    // Reset during beat 2 of a 4-beat read.
    v = '{1'b0, 1'b0, 9'h030, 4'd3, 4'hF, 0, 32'h0, 0};
    ack_lat = 0; d0 = done_cnt; r0 = rsp_seen;
    push_expect(v);
    send_cmd(v);
    n = 0;
    while (rsp_seen == r0 && n < 50) begin @(negedge clk); n++; end
    while (!wb_stb && n < 50) begin @(negedge clk); n++; end
    check("midburst_reached_beat2", (rsp_seen == r0 + 1) && wb_stb, 1);
    #2 rst = 1'b1;
    #1 check("midburst_async_zero", all_outs(), 0);
    @(negedge clk);
    check("midburst_held_zero", all_outs(), 0);
    rst = 1'b0;
    exp_bus.delete(); exp_rsp.delete(); wq.delete();
    repeat (4) @(negedge clk);
    check("midburst_no_done", done_cnt, d0);
    check("midburst_no_more_rsp", rsp_seen, r0 + 1);
    run_cmd(vecs[0], n);
    check("post_reset_cycles", n, 3);
    repeat (2) @(negedge clk);
    check("post_reset_drained", exp_bus.size() + exp_rsp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
